alu_ctrl_mc: RTL and testbench
==============================

# alu_ctrl_mc

Second-generation ALU controller for the single-clock MIPS datapath. It decodes `ALUOp_i`/`funct_i` into a registered ALU control code and sequences multi-cycle multiply/divide operations with a valid/ready handshake and a programmable busy counter. It sits between the main Decoder and the ALU/MDU, and drives `stall_o` to the hazard logic while a multi-cycle operation is in flight.

## Interface
- `CTRL_W`, default 4: width of the ALU control code; must be ≥ 4, upper bits zero-filled.
- `MUL_CYCLES`, default 4: busy cycles for MULT/MULTU; legal range 1..255.
- `DIV_CYCLES`, default 32: busy cycles for DIV/DIVU; legal range 1..255.

Ports:
- `clk_i`  input  1  clock, rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `valid_i`  input  1  decode request present.
- `ready_o`  output  1  controller can accept a request.
- `funct_i`  input  6  R-type function field.
- `ALUOp_i`  input  3  opcode class from the Decoder.
- `flush_i`  input  1  abort the in-flight multi-cycle operation.
- `valid_o`  output  1  `ALUCtrl_o` is valid this cycle (1-cycle pulse per accept).
- `ALUCtrl_o`  output  CTRL_W  registered ALU control code.
- `illegal_o`  output  1  pulses with `valid_o` on an undefined R-type funct.
- `mdu_start_o`  output  1  pulses with `valid_o` on a mul/div accept.
- `stall_o`  output  1  high while in BUSY.
- `done_o`  output  1  1-cycle pulse when a mul/div completes normally.

## Operation
- Accept = `valid_i && ready_o`. `ready_o` = 1 only in IDLE.
- ALUOp map: 000 bne→1010, 001 beq→0110, 010 R-type (funct), 011 addi→0010, 100 sltiu→0111, 101 lui→0011, 110 ori→0001, 111 andi→0000.
- funct map: 100000 add→0010, 100010 sub→0110, 100100 and→0000, 100101 or→0001, 101010 slt→0111, 000011 sra→1000, 000111 srav→1001, 011000 mult→1011, 011001 multu→1100, 011010 div→1101, 011011 divu→1110.
- Any other funct under ALUOp 010: `ALUCtrl_o` = 1111, `illegal_o` = 1; no X is ever driven.
- FSM states: IDLE, BUSY.
  - IDLE → BUSY on accept of mult/multu/div/divu. Counter loads MUL_CYCLES-1 or DIV_CYCLES-1.
  - BUSY: counter decrements each cycle. At counter = 0, pulse `done_o` and return to IDLE.
  - Any other accept stays in IDLE.
- `flush_i` in BUSY: return to IDLE next edge, clear the counter, no `done_o`. `flush_i` in IDLE: ignored; it does not block a same-cycle accept.
- `flush_i` and the terminal count in the same cycle: flush wins, so no `done_o`.
- `ALUCtrl_o` holds its last value until the next accept.

## Timing
- Reset values: `ready_o`=1 after release; `valid_o`, `illegal_o`, `mdu_start_o`, `stall_o`, `done_o` = 0; `ALUCtrl_o` = 0; state IDLE; counter 0.
- Reset asserted mid-BUSY: all outputs go to reset values immediately (async), with no `done_o`.
- Decode latency: 1 cycle. Accept at edge N, so `ALUCtrl_o`/`valid_o` are valid after edge N+1.
- Mul/div with C cycles accepted at edge N:
  - `stall_o` and `ready_o`=0 hold from after edge N+1 through C cycles.
  - `done_o` is high in the last BUSY cycle.
  - `ready_o` returns 1 after edge N+1+C.
- Back-to-back single-cycle ops: one accept per cycle, no bubbles.
- `ready_o` and `stall_o` are registered state decodes; there is no combinational path from `valid_i`.

## Configuration
- `ALU_CTRL_MDU_EN` defined: mult/multu/div/divu decode as above and use the BUSY sequencer.
- Not defined: those four functs decode as illegal (1111, `illegal_o`=1). The FSM never leaves IDLE, and `stall_o`, `mdu_start_o`, `done_o` are tied 0. MUL_CYCLES/DIV_CYCLES are ignored.

## Test plan
- Reset, then ALUOp 011 with `valid_i`=1 → `ALUCtrl_o`=0010 and `valid_o`=1 one cycle later; `ready_o` stays 1.
- Stream of R-type add, sub, slt, srav on consecutive cycles → outputs 0010, 0110, 0111, 1001 on consecutive cycles with no gaps.
- R-type funct 111111 → `ALUCtrl_o`=1111 with `illegal_o` pulse; no X on any output.
- Macro defined, DIV_CYCLES=32, div accepted:
  - `ALUCtrl_o`=1101 and `mdu_start_o` pulse.
  - `stall_o` high for 32 cycles, `done_o` in the 32nd, `ready_o` back 1 cycle after.
  - A `valid_i` presented during BUSY is not accepted.
- Macro defined, mult accepted, `flush_i` on the 2nd BUSY cycle → IDLE next edge, no `done_o`. Repeat with flush on the terminal cycle → still no `done_o`.
- Async `rst_i` pulse mid-div (between clock edges) → all outputs reset at once. Macro undefined: mult → 1111 with `illegal_o`=1 and `stall_o` never asserted.

Source files
------------

// File: rtl/alu_ctrl_mc_if.sv
// alu_ctrl_mc_if: request/response bundle between the Decoder-side master
// and the ALU controller. Signal names keep the datapath's _i/_o suffixes
// as seen from the controller.
interface alu_ctrl_mc_if #(
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic              ready_o;
  logic [5:0]        funct_i;
  logic [2:0]        ALUOp_i;
  logic              flush_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic              illegal_o;
  logic              mdu_start_o;
  logic              stall_o;
  logic              done_o;

  modport slave (
    input  valid_i, funct_i, ALUOp_i, flush_i,
    output ready_o, valid_o, ALUCtrl_o, illegal_o, mdu_start_o, stall_o, done_o
  );

  modport master (
    output valid_i, funct_i, ALUOp_i, flush_i,
    input  ready_o, valid_o, ALUCtrl_o, illegal_o, mdu_start_o, stall_o, done_o
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: registered ALU control decode plus an IDLE/BUSY sequencer for
// multi-cycle multiply/divide. Optional feature macro: ALU_CTRL_MDU_EN.
// Without it, mult/multu/div/divu decode as illegal, so the sequencer never
// leaves IDLE and stall/mdu_start/done stay 0.
module alu_ctrl_mc #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_ctrl_mc_if.slave bus
);
  localparam logic [7:0] MUL_LD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LD = 8'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  code;
  logic        is_ill, is_mdu, is_div;
  logic        accept;
  logic [1:0]  vld_pipe;
  logic [3:0]  ctrl_q;
  logic        ill_q, start_q;

  assign accept      = bus.valid_i && (state == IDLE);
  assign vld_pipe[0] = accept;

  // Decode ALUOp/funct; unknown R-type functs map to 1111 so no X escapes.
  always_comb begin
    code   = 4'b1111;
    is_ill = 1'b0;
    is_mdu = 1'b0;
    is_div = 1'b0;
    case (bus.ALUOp_i)
      3'b000: code = 4'b1010;
      3'b001: code = 4'b0110;
      3'b010: begin
        case (bus.funct_i)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b101010: code = 4'b0111;
          6'b000011: code = 4'b1000;
          6'b000111: code = 4'b1001;
`ifdef ALU_CTRL_MDU_EN
          6'b011000: begin code = 4'b1011; is_mdu = 1'b1; end
          6'b011001: begin code = 4'b1100; is_mdu = 1'b1; end
          6'b011010: begin code = 4'b1101; is_mdu = 1'b1; is_div = 1'b1; end
          6'b011011: begin code = 4'b1110; is_mdu = 1'b1; is_div = 1'b1; end
`endif
          default: begin code = 4'b1111; is_ill = 1'b1; end
        endcase
      end
      3'b011: code = 4'b0010;
      3'b100: code = 4'b0111;
      3'b101: code = 4'b0011;
      3'b110: code = 4'b0001;
      default: code = 4'b0000;
    endcase
  end

  // Output register: control code held until the next accept, flags pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe[1] <= 1'b0;
      ctrl_q      <= 4'b0000;
      ill_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      ill_q       <= accept && is_ill;
      start_q     <= accept && is_mdu;
      if (accept) ctrl_q <= code;
    end
  end

  // State and busy counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: flush beats the terminal count so an aborted op never reports done.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept && is_mdu) begin
          state_n = BUSY;
          cnt_n   = is_div ? DIV_LD : MUL_LD;
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else if (cnt == 8'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign bus.ready_o     = (state == IDLE);
  assign bus.stall_o     = (state == BUSY);
  assign bus.done_o      = (state == BUSY) && (cnt == 8'd0) && !bus.flush_i;
  assign bus.valid_o     = vld_pipe[1];
  assign bus.ALUCtrl_o   = CTRL_W'(ctrl_q);
  assign bus.illegal_o   = ill_q;
  assign bus.mdu_start_o = start_q;
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc; MDU checks follow ALU_CTRL_MDU_EN.
module tb_alu_ctrl_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_ctrl_mc_if #(.CTRL_W(4)) bus ();

  alu_ctrl_mc #(.CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [2:0] op, input logic [5:0] fn);
    bus.valid_i = v;
    bus.ALUOp_i = op;
    bus.funct_i = fn;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, bus.ready_o, 1);
    chk({tag, "_valid"}, bus.valid_o, 0);
    chk({tag, "_ctrl"},  bus.ALUCtrl_o, 0);
    chk({tag, "_ill"},   bus.illegal_o, 0);
    chk({tag, "_start"}, bus.mdu_start_o, 0);
    chk({tag, "_stall"}, bus.stall_o, 0);
    chk({tag, "_done"},  bus.done_o, 0);
  endtask

  logic [2:0] ops  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [3:0] opex [6] = '{4'hA, 4'h6, 4'h7, 4'h3, 4'h1, 4'h0};
  logic [5:0] fns  [7] = '{6'b100000, 6'b100010, 6'b101010, 6'b000111, 6'b100100, 6'b100101, 6'b000011};
  logic [3:0] fnex [7] = '{4'h2, 4'h6, 4'h7, 4'h9, 4'h0, 4'h1, 4'h8};

  initial begin
    req(1'b0, 3'b000, 6'b0);
    bus.flush_i = 1'b0;

    // reset values
    #12;
    chk_reset_outs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_rel");

    // addi
    @(negedge clk);
    req(1'b1, 3'b011, 6'b0);
    tick();
    chk("addi_ctrl", bus.ALUCtrl_o, 4'h2);
    chk("addi_valid", bus.valid_o, 1);
    chk("addi_ready", bus.ready_o, 1);

    // back-to-back R-type stream, no bubbles
    for (int i = 0; i < 7; i++) begin
      req(1'b1, 3'b010, fns[i]);
      tick();
      chk($sformatf("rtype%0d_ctrl", i), bus.ALUCtrl_o, fnex[i]);
      chk($sformatf("rtype%0d_valid", i), bus.valid_o, 1);
      chk($sformatf("rtype%0d_ill", i), bus.illegal_o, 0);
    end

    // non R-type classes
    for (int i = 0; i < 6; i++) begin
      req(1'b1, ops[i], 6'b111111);
      tick();
      chk($sformatf("op%0d_ctrl", i), bus.ALUCtrl_o, opex[i]);
    end

    // idle cycle: valid drops, ctrl holds
    req(1'b0, 3'b011, 6'b0);
    tick();
    chk("idle_valid", bus.valid_o, 0);
    chk("idle_hold", bus.ALUCtrl_o, 4'h0);

    // illegal funct
    req(1'b1, 3'b010, 6'b111111);
    tick();
    chk("ill_ctrl", bus.ALUCtrl_o, 4'hF);
    chk("ill_flag", bus.illegal_o, 1);
    chk("ill_nox", {31'd0, ^{bus.ALUCtrl_o, bus.valid_o, bus.ready_o, bus.illegal_o,
                              bus.mdu_start_o, bus.stall_o, bus.done_o}} !== {31'd0, 1'bx}, 1);
    req(1'b0, 3'b000, 6'b0);
    tick();
    chk("ill_pulse_end", bus.illegal_o, 0);

    // flush in IDLE does not block accept
    bus.flush_i = 1'b1;
    req(1'b1, 3'b011, 6'b0);
    tick();
    bus.flush_i = 1'b0;
    chk("idle_flush_ctrl", bus.ALUCtrl_o, 4'h2);
    chk("idle_flush_valid", bus.valid_o, 1);

`ifdef ALU_CTRL_MDU_EN
    // div: 32 busy cycles, done in the last, request during BUSY ignored
    req(1'b1, 3'b010, 6'b011010);
    tick();
    chk("div_ctrl", bus.ALUCtrl_o, 4'hD);
    chk("div_start", bus.mdu_start_o, 1);
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("div_stall%0d", k), bus.stall_o, 1);
      chk($sformatf("div_ready%0d", k), bus.ready_o, 0);
      chk($sformatf("div_done%0d", k), bus.done_o, (k == 32) ? 1 : 0);
      if (k == 2) chk("div_start_end", bus.mdu_start_o, 0);
      if (k > 1) chk($sformatf("div_valid%0d", k), bus.valid_o, 0);
      if (k < 32) req(1'b1, 3'b011, 6'b0);
      else req(1'b0, 3'b000, 6'b0);
      tick();
    end
    chk("div_ready_back", bus.ready_o, 1);
    chk("div_stall_end", bus.stall_o, 0);
    chk("div_no_accept", bus.ALUCtrl_o, 4'hD);
    chk("div_no_valid", bus.valid_o, 0);

    // mult flushed on 2nd BUSY cycle
    req(1'b1, 3'b010, 6'b011000);
    tick();
    req(1'b0, 3'b000, 6'b0);
    chk("mulf_ctrl", bus.ALUCtrl_o, 4'hB);
    chk("mulf_stall1", bus.stall_o, 1);
    tick();
    chk("mulf_stall2", bus.stall_o, 1);
    bus.flush_i = 1'b1;
    #1;
    chk("mulf_done2", bus.done_o, 0);
    tick();
    bus.flush_i = 1'b0;
    chk("mulf_idle", bus.ready_o, 1);
    chk("mulf_stall_off", bus.stall_o, 0);
    chk("mulf_done_off", bus.done_o, 0);

    // full multu afterwards: counter reloads, done on 4th cycle
    req(1'b1, 3'b010, 6'b011001);
    tick();
    req(1'b0, 3'b000, 6'b0);
    chk("mulu_ctrl", bus.ALUCtrl_o, 4'hC);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mulu_stall%0d", k), bus.stall_o, 1);
      chk($sformatf("mulu_done%0d", k), bus.done_o, (k == 4) ? 1 : 0);
      tick();
    end
    chk("mulu_ready", bus.ready_o, 1);

    // mult flushed on terminal cycle: flush wins
    req(1'b1, 3'b010, 6'b011000);
    tick();
    req(1'b0, 3'b000, 6'b0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("mult_done%0d", k), bus.done_o, 0);
      tick();
    end
    chk("mult_term_stall", bus.stall_o, 1);
    bus.flush_i = 1'b1;
    #1;
    chk("mult_term_done", bus.done_o, 0);
    tick();
    bus.flush_i = 1'b0;
    chk("mult_term_idle", bus.ready_o, 1);
    chk("mult_term_done_off", bus.done_o, 0);
`else
    // without the MDU feature, mul/div are illegal and never stall
    req(1'b1, 3'b010, 6'b011000);
    tick();
    req(1'b0, 3'b000, 6'b0);
    chk("nomdu_mult_ctrl", bus.ALUCtrl_o, 4'hF);
    chk("nomdu_mult_ill", bus.illegal_o, 1);
    chk("nomdu_mult_start", bus.mdu_start_o, 0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("nomdu_stall%0d", k), bus.stall_o, 0);
      chk($sformatf("nomdu_ready%0d", k), bus.ready_o, 1);
      chk($sformatf("nomdu_done%0d", k), bus.done_o, 0);
      tick();
    end
    req(1'b1, 3'b010, 6'b011011);
    tick();
    chk("nomdu_divu_ctrl", bus.ALUCtrl_o, 4'hF);
    chk("nomdu_divu_ill", bus.illegal_o, 1);
    chk("nomdu_divu_stall", bus.stall_o, 0);
`endif

    // async reset between edges after a div accept
    req(1'b1, 3'b010, 6'b011010);
    tick();
    req(1'b0, 3'b000, 6'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs("async_rel");
    req(1'b1, 3'b110, 6'b0);
    tick();
    req(1'b0, 3'b000, 6'b0);
    chk("post_rst_ctrl", bus.ALUCtrl_o, 4'h1);
    chk("post_rst_valid", bus.valid_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
